// File: rtl/cam_pkg.sv
// -----------------------------------------------------------------------------
// cam_pkg
// Shared definitions for the camera capture path and the VGA display block:
// framebuffer geometry, pixel word layout and the capture FSM encoding.
// -----------------------------------------------------------------------------
package cam_pkg;

    // Framebuffer geometry
    localparam int c_img_cols    = 80;
    localparam int c_img_rows    = 60;
    localparam int c_img_pxls    = c_img_cols * c_img_rows;
    localparam int c_nb_img_pxls = 13;

    // Framebuffer word layout
    localparam int c_nb_red   = 5;
    localparam int c_nb_green = 5;
    localparam int c_nb_blue  = 6;
    localparam int c_nb_buf   = c_nb_red + c_nb_green + c_nb_blue;

    typedef struct packed {
        logic [c_nb_red-1:0]   red;
        logic [c_nb_green-1:0] green;
        logic [c_nb_blue-1:0]  blue;
    } fb_pixel_t;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_CAPT = 1'b1
    } cam_state_t;

    // RGB565 byte pair -> framebuffer word. The green LSB is dropped and the
    // 5-bit blue sits in the upper bits of the 6-bit field with a zero below.
    function automatic fb_pixel_t pack_rgb565(input logic [7:0] b0, input logic [7:0] b1);
        fb_pixel_t pix;
        pix.red   = b0[7:3];
        pix.green = {b0[2:0], b1[7:6]};
        pix.blue  = {b1[4:0], 1'b0};
        return pix;
    endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// -----------------------------------------------------------------------------
// cam_sync_edge
// Two-flop synchronizer followed by a registered rise/fall detector for one
// asynchronous camera control line.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous reset, active high
//   sig_i    in   asynchronous input
//   level_o  out  synchronized level, aligned with rise_o/fall_o
//   rise_o   out  one-clk pulse on a 0->1 transition
//   fall_o   out  one-clk pulse on a 1->0 transition
// -----------------------------------------------------------------------------
module cam_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;
    logic fall_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= sig_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
            fall_q <= ~sync_q & prev_q;
        end
    end

    // prev_q is the same sample the edge flops compared against, so the level
    // and the edge pulses describe the same instant.
    assign level_o = prev_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/cam_capture.sv
// -----------------------------------------------------------------------------
// cam_capture
// Camera-side framebuffer writer. Oversamples an OV7670-style parallel bus in
// the clk domain, assembles byte pairs into pixels, decimates the camera frame
// by 2^c_dec_log2 in both directions and writes one word per kept pixel.
//
// Ports:
//   clk            in   system clock (>= 4x cam_pclk)
//   rst            in   asynchronous reset, active high
//   rgbmode        in   1: RGB565, 0: YUV422 (Y kept); sampled at frame start
//   cam_pclk       in   camera pixel clock, sampled as data
//   cam_vsync      in   camera vertical sync, active high
//   cam_href       in   camera line valid, active high
//   cam_data       in   camera byte
//   frame_we       out  write strobe, one clk wide
//   frame_addr     out  write address
//   frame_wr_data  out  write data
//   frame_done     out  pulse with the write of the last framebuffer word
//
// Build option: define CAM_CAPTURE_TESTPAT_EN to write a coordinate test
// pattern instead of camera data (timing and addressing unchanged).
// -----------------------------------------------------------------------------
module cam_capture #(
    parameter int c_cam_cols    = 640,
    parameter int c_cam_rows    = 480,
    parameter int c_dec_log2    = 3,
    parameter int c_img_cols    = cam_pkg::c_img_cols,
    parameter int c_img_rows    = cam_pkg::c_img_rows,
    parameter int c_img_pxls    = c_img_cols * c_img_rows,
    parameter int c_nb_img_pxls = cam_pkg::c_nb_img_pxls,
    parameter int c_nb_buf      = cam_pkg::c_nb_buf
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rgbmode,
    input  logic                     cam_pclk,
    input  logic                     cam_vsync,
    input  logic                     cam_href,
    input  logic [7:0]               cam_data,
    output logic                     frame_we,
    output logic [c_nb_img_pxls-1:0] frame_addr,
    output logic [c_nb_buf-1:0]      frame_wr_data,
    output logic                     frame_done
);

    import cam_pkg::*;

    localparam int c_nb_col = $clog2(c_cam_cols + 1);
    localparam int c_nb_row = $clog2(c_cam_rows + 1);

    localparam logic [c_nb_col-1:0]      c_col_lim  = c_nb_col'(c_cam_cols);
    localparam logic [c_nb_row-1:0]      c_row_lim  = c_nb_row'(c_cam_rows);
    localparam logic [c_nb_col-1:0]      c_col_max  = '1;
    localparam logic [c_nb_row-1:0]      c_row_max  = '1;
    localparam logic [c_nb_img_pxls-1:0] c_addr_lim = c_nb_img_pxls'(c_img_pxls);
    localparam logic [c_nb_img_pxls-1:0] c_addr_end = c_nb_img_pxls'(c_img_pxls - 1);

    // ---------------------------------------------------------------- sync
    logic pclk_lvl,  pclk_rise,  pclk_fall;
    logic href_lvl,  href_rise,  href_fall;
    logic vsync_lvl, vsync_rise, vsync_fall;

    cam_sync_edge u_sync_pclk (
        .clk     (clk),
        .rst     (rst),
        .sig_i   (cam_pclk),
        .level_o (pclk_lvl),
        .rise_o  (pclk_rise),
        .fall_o  (pclk_fall)
    );

    cam_sync_edge u_sync_href (
        .clk     (clk),
        .rst     (rst),
        .sig_i   (cam_href),
        .level_o (href_lvl),
        .rise_o  (href_rise),
        .fall_o  (href_fall)
    );

    cam_sync_edge u_sync_vsync (
        .clk     (clk),
        .rst     (rst),
        .sig_i   (cam_vsync),
        .level_o (vsync_lvl),
        .rise_o  (vsync_rise),
        .fall_o  (vsync_fall)
    );

    logic sync_unused;
    assign sync_unused = ^{pclk_lvl, pclk_fall, vsync_lvl};

    // Data only needs the two-flop delay: the camera holds it for at least
    // half a pclk period (>= 2 clk) around the rising edge.
    logic [7:0] data_meta_q;
    logic [7:0] data_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_meta_q <= '0;
            data_sync_q <= '0;
        end else begin
            data_meta_q <= cam_data;
            data_sync_q <= data_meta_q;
        end
    end

    // ---------------------------------------------------------------- state
    cam_state_t               state_q,   state_d;
    logic                     rgb_q,     rgb_d;
    logic                     byte_ph_q, byte_ph_d;
    logic [7:0]               b0_q,      b0_d;
    logic [c_nb_col-1:0]      col_q,     col_d;
    logic [c_nb_row-1:0]      row_q,     row_d;
    logic [c_nb_img_pxls-1:0] addr_q,    addr_d;
    logic                     we_q,      we_d;
    logic [c_nb_buf-1:0]      wdata_q,   wdata_d;
    logic                     done_q,    done_d;

    logic [c_nb_col-1:0] col_eff;
    logic                ph_eff;
    logic                byte_en;
    logic                keep;
    logic [c_nb_buf-1:0] pix;

`ifdef CAM_CAPTURE_TESTPAT_EN
    logic [6:0] img_col;
    logic [5:0] img_row;
    logic       pat_unused;
    assign pat_unused = ^{rgb_q, b0_q};
`endif

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        rgb_d     = rgb_q;
        byte_ph_d = byte_ph_q;
        b0_d      = b0_q;
        col_d     = col_q;
        row_d     = row_q;
        addr_d    = addr_q;
        we_d      = 1'b0;
        wdata_d   = wdata_q;
        done_d    = 1'b0;

        // An href rising edge restarts the line even if a pclk edge lands in
        // the same cycle; that pclk edge is then the first byte of the line.
        col_eff = href_rise ? '0 : col_q;
        ph_eff  = href_rise ? 1'b0 : byte_ph_q;

        // The href_fall term lets the last pixel complete when its pclk edge
        // coincides with the end of the line.
        byte_en = pclk_rise && (href_lvl || href_fall);

        keep = (col_eff[c_dec_log2-1:0] == '0) &&
               (row_q[c_dec_log2-1:0] == '0) &&
               (col_eff < c_col_lim) &&
               (row_q < c_row_lim) &&
               (addr_q < c_addr_lim);

`ifdef CAM_CAPTURE_TESTPAT_EN
        img_col = 7'(col_eff >> c_dec_log2);
        img_row = 6'(row_q >> c_dec_log2);
        pix     = {img_col[6:2], img_row[5:1], img_col[5:0]};
`else
        pix = rgb_q ? pack_rgb565(b0_q, data_sync_q) : {8'h00, b0_q};
`endif

        // Address advances the cycle after the strobe so it is stable while
        // frame_we is high; the write gate keeps it from passing c_img_pxls.
        if (we_q) begin
            addr_d = addr_q + c_nb_img_pxls'(1);
        end

        case (state_q)
            ST_WAIT: begin
                if (vsync_fall) begin
                    state_d   = ST_CAPT;
                    rgb_d     = rgbmode;
                    byte_ph_d = 1'b0;
                    col_d     = '0;
                    row_d     = '0;
                    addr_d    = '0;
                end
            end

            ST_CAPT: begin
                if (vsync_rise) begin
                    state_d = ST_WAIT;
                end else begin
                    byte_ph_d = ph_eff;
                    col_d     = col_eff;
                    if (byte_en) begin
                        if (!ph_eff) begin
                            b0_d      = data_sync_q;
                            byte_ph_d = 1'b1;
                        end else begin
                            byte_ph_d = 1'b0;
                            if (col_eff != c_col_max) begin
                                col_d = col_eff + c_nb_col'(1);
                            end
                            if (keep) begin
                                we_d    = 1'b1;
                                wdata_d = pix;
                                done_d  = (addr_q == c_addr_end);
                            end
                        end
                    end
                    // Uses the pre-increment row above, so a pixel finishing
                    // on the same cycle belongs to the line that just ended.
                    if (href_fall && (row_q != c_row_max)) begin
                        row_d = row_q + c_nb_row'(1);
                    end
                end
            end

            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_WAIT;
            rgb_q     <= 1'b0;
            byte_ph_q <= 1'b0;
            b0_q      <= '0;
            col_q     <= '0;
            row_q     <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rgb_q     <= rgb_d;
            byte_ph_q <= byte_ph_d;
            b0_q      <= b0_d;
            col_q     <= col_d;
            row_q     <= row_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
        end
    end

    assign frame_we      = we_q;
    assign frame_addr    = addr_q;
    assign frame_wr_data = wdata_q;
    assign frame_done    = done_q;

endmodule

// File: tb/tb_cam_capture.sv
// -----------------------------------------------------------------------------
// tb_cam_capture
// Directed bench for cam_capture. The camera geometry is scaled down
// (32x24 camera, decimation 8 -> 4x3 framebuffer, 12 words) so whole frames
// stay short; all framebuffer-boundary behaviour scales with it.
// -----------------------------------------------------------------------------
module tb_cam_capture;

    localparam int c_cols = 32;
    localparam int c_rows = 24;
    localparam int c_pxls = 12;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        rgbmode   = 1'b1;
    logic        cam_pclk  = 1'b1;
    logic        cam_vsync = 1'b0;
    logic        cam_href  = 1'b0;
    logic [7:0]  cam_data  = 8'h00;
    logic        frame_we;
    logic [12:0] frame_addr;
    logic [15:0] frame_wr_data;
    logic        frame_done;

    cam_capture #(
        .c_cam_cols    (c_cols),
        .c_cam_rows    (c_rows),
        .c_dec_log2    (3),
        .c_img_cols    (4),
        .c_img_rows    (3),
        .c_img_pxls    (c_pxls),
        .c_nb_img_pxls (13),
        .c_nb_buf      (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rgbmode       (rgbmode),
        .cam_pclk      (cam_pclk),
        .cam_vsync     (cam_vsync),
        .cam_href      (cam_href),
        .cam_data      (cam_data),
        .frame_we      (frame_we),
        .frame_addr    (frame_addr),
        .frame_wr_data (frame_wr_data),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ------------------------------------------------------------ monitor
    int          wr_cnt;
    int          done_cnt;
    int          stray_done;
    int          seq_err;
    logic [12:0] exp_seq;
    logic [12:0] done_addr;
    logic [12:0] log_addr[$];
    logic [15:0] log_data[$];

    always @(negedge clk) begin
        if (frame_done === 1'b1 && frame_we !== 1'b1) stray_done++;
        if (frame_we === 1'b1) begin
            wr_cnt++;
            log_addr.push_back(frame_addr);
            log_data.push_back(frame_wr_data);
            if (frame_addr !== exp_seq) seq_err++;
            exp_seq = exp_seq + 13'd1;
            if (frame_done === 1'b1) begin
                done_cnt++;
                done_addr = frame_addr;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ drivers
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_stats();
        wr_cnt     = 0;
        done_cnt   = 0;
        stray_done = 0;
        seq_err    = 0;
        exp_seq    = '0;
        done_addr  = '0;
        log_addr.delete();
        log_data.delete();
    endtask

    // Data changes with the pclk falling edge and is held 4 clk either side
    // of the rising edge.
    task automatic send_byte(input logic [7:0] b);
        cam_data = b;
        cam_pclk = 1'b0;
        tick(4);
        cam_pclk = 1'b1;
        tick(4);
    endtask

    task automatic send_line(input int n_pix, input int hit_col,
                             input logic [7:0] hb0, input logic [7:0] hb1,
                             input logic [7:0] fb);
        cam_href = 1'b1;
        for (int c = 0; c < n_pix; c++) begin
            if (c == hit_col) begin
                send_byte(hb0);
                send_byte(hb1);
            end else begin
                send_byte(fb);
                send_byte(fb);
            end
        end
        cam_href = 1'b0;
        tick(8);
    endtask

    task automatic frame_start();
        cam_vsync = 1'b1;
        tick(8);
        cam_vsync = 1'b0;
        tick(8);
    endtask

    task automatic frame_end();
        cam_vsync = 1'b1;
        tick(8);
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        n_checks++;
        if (frame_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", frame_we); end
        n_checks++;
        if (frame_addr !== 13'd0) begin n_fail++; $display("FAIL reset_addr got=%0d exp=0", frame_addr); end
        n_checks++;
        if (frame_wr_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data got=%h exp=0000", frame_wr_data); end
        n_checks++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", frame_done); end
        rst = 1'b0;
        tick(4);
        clear_stats();
        // A line with no frame start must be ignored.
        send_line(c_cols, -1, 8'h00, 8'h00, 8'hFF);
        n_checks++;
        if (wr_cnt !== 0) begin n_fail++; $display("FAIL reset_idle_writes got=%0d exp=0", wr_cnt); end
    endtask

    task automatic test_rgb_pixel();
        clear_stats();
        rgbmode = 1'b1;
        frame_start();
        send_line(c_cols, 0, 8'hF8, 8'h1F, 8'h00);
        frame_end();
        n_checks++;
        if (wr_cnt !== 4) begin n_fail++; $display("FAIL rgb_count got=%0d exp=4", wr_cnt); end
        n_checks++;
        if (log_addr.size() < 2) begin
            n_fail++; $display("FAIL rgb_log got=%0d entries exp=4", log_addr.size());
        end else begin
            if (log_addr[0] !== 13'd0) begin n_fail++; $display("FAIL rgb_addr got=%0d exp=0", log_addr[0]); end
            n_checks++;
            if (log_data[0] !== 16'hF83E) begin n_fail++; $display("FAIL rgb_data got=%h exp=F83E", log_data[0]); end
            n_checks++;
            if (log_data[1] !== 16'h0000) begin n_fail++; $display("FAIL rgb_data_col8 got=%h exp=0000", log_data[1]); end
        end
        n_checks++;
        if (done_cnt !== 0) begin n_fail++; $display("FAIL rgb_no_done got=%0d exp=0", done_cnt); end
    endtask

    task automatic test_yuv_decimation();
        clear_stats();
        rgbmode = 1'b0;
        frame_start();
        // Changing rgbmode mid-frame must not affect this frame.
        rgbmode = 1'b1;
        send_line(c_cols, 8, 8'hA5, 8'h80, 8'h3C);
        frame_end();
        n_checks++;
        if (wr_cnt !== 4) begin n_fail++; $display("FAIL yuv_count got=%0d exp=4", wr_cnt); end
        n_checks++;
        if (log_addr.size() < 2) begin
            n_fail++; $display("FAIL yuv_log got=%0d entries exp=4", log_addr.size());
        end else begin
            if (log_addr[1] !== 13'd1) begin n_fail++; $display("FAIL yuv_addr got=%0d exp=1", log_addr[1]); end
            n_checks++;
            if (log_data[1] !== 16'h00A5) begin n_fail++; $display("FAIL yuv_data got=%h exp=00A5", log_data[1]); end
            n_checks++;
            if (log_data[0] !== 16'h003C) begin n_fail++; $display("FAIL yuv_held_mode got=%h exp=003C", log_data[0]); end
        end
    endtask

    task automatic test_full_frame();
        clear_stats();
        rgbmode = 1'b1;
        frame_start();
        for (int r = 0; r < c_rows; r++) send_line(c_cols, -1, 8'h00, 8'h00, 8'hFF);
        n_checks++;
        if (wr_cnt !== c_pxls) begin n_fail++; $display("FAIL full_count got=%0d exp=%0d", wr_cnt, c_pxls); end
        n_checks++;
        if (seq_err !== 0) begin n_fail++; $display("FAIL full_order got=%0d out-of-order exp=0", seq_err); end
        n_checks++;
        if (done_cnt !== 1 || done_addr !== 13'd11) begin
            n_fail++; $display("FAIL full_done got=%0d pulses at %0d exp=1 at 11", done_cnt, done_addr);
        end
        n_checks++;
        if (stray_done !== 0) begin n_fail++; $display("FAIL full_stray_done got=%0d exp=0", stray_done); end
        n_checks++;
        if (frame_addr !== 13'd12) begin n_fail++; $display("FAIL full_addr_end got=%0d exp=12", frame_addr); end
        n_checks++;
        if (log_data.size() > 0 && log_data[0] !== 16'hFFFE) begin
            n_fail++; $display("FAIL full_data got=%h exp=FFFE", log_data[0]);
        end
        frame_end();
    endtask

    task automatic test_abort();
        clear_stats();
        frame_start();
        for (int r = 0; r < 10; r++) send_line(c_cols, -1, 8'h00, 8'h00, 8'hFF);
        frame_end();
        n_checks++;
        if (wr_cnt !== 8) begin n_fail++; $display("FAIL abort_count got=%0d exp=8", wr_cnt); end
        n_checks++;
        if (done_cnt !== 0 || stray_done !== 0) begin
            n_fail++; $display("FAIL abort_done got=%0d exp=0", done_cnt + stray_done);
        end
        clear_stats();
        frame_start();
        send_line(c_cols, -1, 8'h00, 8'h00, 8'hFF);
        frame_end();
        n_checks++;
        if (wr_cnt !== 4) begin n_fail++; $display("FAIL abort_next_count got=%0d exp=4", wr_cnt); end
        n_checks++;
        if (log_addr.size() == 0 || log_addr[0] !== 13'd0) begin
            n_fail++; $display("FAIL abort_next_addr got=%0d exp=0", (log_addr.size() == 0) ? -1 : int'(log_addr[0]));
        end
    endtask

    task automatic test_extra_lines();
        clear_stats();
        frame_start();
        for (int r = 0; r < 30; r++) send_line(c_cols + 8, -1, 8'h00, 8'h00, 8'hFF);
        n_checks++;
        if (wr_cnt !== c_pxls) begin n_fail++; $display("FAIL extra_count got=%0d exp=%0d", wr_cnt, c_pxls); end
        n_checks++;
        if (seq_err !== 0) begin n_fail++; $display("FAIL extra_order got=%0d out-of-order exp=0", seq_err); end
        n_checks++;
        if (done_cnt !== 1) begin n_fail++; $display("FAIL extra_done got=%0d exp=1", done_cnt); end
        n_checks++;
        if (frame_addr !== 13'd12) begin n_fail++; $display("FAIL extra_addr_hold got=%0d exp=12", frame_addr); end
        frame_end();
    endtask

    task automatic test_reset_mid();
        bit got;
        clear_stats();
        rgbmode = 1'b1;
        frame_start();
        cam_href = 1'b1;
        for (int c = 0; c < 16; c++) begin
            send_byte(8'hFF);
            send_byte(8'hFF);
        end
        send_byte(8'hFF);
        cam_data = 8'hFF;
        cam_pclk = 1'b0;
        tick(4);
        cam_pclk = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            tick(1);
            if (frame_we === 1'b1) got = 1'b1;
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL rst_mid_we got=timeout exp=write within 12 clk"); end
        n_checks++;
        if (frame_addr !== 13'd2) begin n_fail++; $display("FAIL rst_mid_pre_addr got=%0d exp=2", frame_addr); end
        rst = 1'b1;
        #1;
        n_checks++;
        if (frame_we !== 1'b0) begin n_fail++; $display("FAIL rst_mid_we_clr got=%b exp=0", frame_we); end
        n_checks++;
        if (frame_addr !== 13'd0) begin n_fail++; $display("FAIL rst_mid_addr got=%0d exp=0", frame_addr); end
        n_checks++;
        if (frame_wr_data !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_data got=%h exp=0000", frame_wr_data); end
        n_checks++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got=%b exp=0", frame_done); end
        tick(3);
        rst = 1'b0;
        tick(1);
        clear_stats();
        for (int c = 17; c < c_cols; c++) begin
            send_byte(8'hFF);
            send_byte(8'hFF);
        end
        cam_href = 1'b0;
        tick(8);
        send_line(c_cols, -1, 8'h00, 8'h00, 8'hFF);
        send_line(c_cols, -1, 8'h00, 8'h00, 8'hFF);
        n_checks++;
        if (wr_cnt !== 0) begin n_fail++; $display("FAIL rst_mid_quiet got=%0d writes exp=0", wr_cnt); end
        frame_start();
        send_line(c_cols, -1, 8'h00, 8'h00, 8'hFF);
        frame_end();
        n_checks++;
        if (wr_cnt !== 4 || log_addr.size() == 0 || log_addr[0] !== 13'd0) begin
            n_fail++; $display("FAIL rst_mid_resume got=%0d writes exp=4 from addr 0", wr_cnt);
        end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_rgb_pixel();
        test_yuv_decimation();
        test_full_frame();
        test_abort();
        test_extra_lines();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
